// File: rtl/wram_pkg.sv
// rtl/wram_pkg.sv - shared types and constants for the work-RAM arbiter
package wram_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] IDLE_BUS = 8'hFF;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

endpackage

// File: rtl/wram_prio_sel.sv
// rtl/wram_prio_sel.sv - combinational CPU/DMA priority select with starvation override
module wram_prio_sel #(
    parameter int STARVE_MAX = 4
) (
    input  logic       enable,
    input  logic       cpu_req,
    input  logic       dma_req,
    input  logic [3:0] starve_cnt,
    output logic       cpu_gnt,
    output logic       dma_gnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic cpu_force;

    // DMA normally wins; a CPU that has waited STARVE_MAX cycles takes this one.
    assign cpu_force = cpu_req && (starve_cnt == STARVE_LIM);
    assign dma_gnt   = enable && dma_req && !cpu_force;
    assign cpu_gnt   = enable && cpu_req && !(dma_req && !cpu_force);

endmodule

// File: rtl/wram_arbiter.sv
// rtl/wram_arbiter.sv - two-port (CPU, DMA) arbiter onto one synchronous work RAM
module wram_arbiter
    import wram_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,

    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_din,
    output logic              sram_ce1,
    output logic              sram_ce2,
    output logic              sram_oe,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       tag_valid;
    owner_e     tag_owner;
    logic       rd_grant;
    owner_e     rd_owner;
    logic       tag_live;

    wram_prio_sel #(.STARVE_MAX(STARVE_MAX)) u_prio_sel (
        .enable     (!rst),
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .starve_cnt (starve_cnt),
        .cpu_gnt    (cpu_gnt),
        .dma_gnt    (dma_gnt)
    );

    always_comb begin
        sram_a   = '0;
        sram_din = '0;
        sram_ce1 = 1'b0;
        sram_ce2 = 1'b0;
        rd_grant = 1'b0;
        rd_owner = OWN_CPU;
        if (cpu_gnt) begin
            sram_a = cpu_addr;
            if (cpu_we) begin
                sram_din = cpu_wdata;
                sram_ce1 = 1'b1;
                sram_ce2 = 1'b1;
            end else begin
                rd_grant = 1'b1;
                rd_owner = OWN_CPU;
            end
        end else if (dma_gnt) begin
            sram_a = dma_addr;
            if (dma_we) begin
                sram_din = dma_wdata;
                sram_ce1 = 1'b1;
                sram_ce2 = 1'b1;
            end else begin
                rd_grant = 1'b1;
                rd_owner = OWN_DMA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (cpu_req && !cpu_gnt) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // The tag is rewritten every cycle, so a read can follow a read with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= 1'b0;
            tag_owner <= OWN_CPU;
        end else begin
            tag_valid <= rd_grant;
            tag_owner <= rd_owner;
        end
    end

    // Masking with rst drops a read whose data would land in a reset cycle.
    assign tag_live   = tag_valid && !rst;
    assign sram_oe    = tag_live;
    assign cpu_rvalid = tag_live && (tag_owner == OWN_CPU);
    assign dma_rvalid = tag_live && (tag_owner == OWN_DMA);
    assign cpu_rdata  = cpu_rvalid ? sram_dout : IDLE_BUS;
    assign dma_rdata  = dma_rvalid ? sram_dout : IDLE_BUS;

endmodule

// File: tb/tb_wram_arbiter.sv
// tb/tb_wram_arbiter.sv - self-checking bench for wram_arbiter with a behavioural RAM and reference model
module tb_wram_arbiter;
    import wram_pkg::*;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [12:0] dma_addr = '0;
    logic [7:0]  dma_wdata = '0;
    logic        dma_gnt, dma_rvalid;
    logic [7:0]  dma_rdata;
    logic [12:0] sram_a;
    logic [7:0]  sram_din;
    logic        sram_ce1, sram_ce2, sram_oe;
    logic [7:0]  sram_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wram_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .sram_a     (sram_a),
        .sram_din   (sram_din),
        .sram_ce1   (sram_ce1),
        .sram_ce2   (sram_ce2),
        .sram_oe    (sram_oe),
        .sram_dout  (sram_dout)
    );

    function automatic logic [7:0] init_val(input logic [12:0] a);
        return (a == 13'h0123) ? 8'h5A : 8'(a * 13'd37 + 13'd11);
    endfunction

    // Behavioural synchronous RAM: data for the address presented appears next cycle.
    logic [7:0] mem [8192];
    bit         wr  [8192];
    always @(posedge clk) begin
        if (sram_ce1 && sram_ce2) begin
            mem[sram_a] <= sram_din;
            wr[sram_a]  <= 1'b1;
        end
        sram_dout <= wr[sram_a] ? mem[sram_a] : init_val(sram_a);
    end

    // Reference model state
    int         starve = 0;
    bit         pv = 1'b0;
    owner_e     po = OWN_CPU;
    logic [7:0] pd = '0;
    logic [7:0] sh  [8192];
    bit         shw [8192];

    logic       last_cpu_gnt, last_cpu_rvalid, last_dma_rvalid;
    logic [7:0] last_cpu_rdata;

    function automatic logic [7:0] sh_read(input logic [12:0] a);
        return shw[a] ? sh[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cycle(input bit r,
                         input bit cr, input bit cw, input logic [12:0] ca, input logic [7:0] cd,
                         input bit dr, input bit dw, input logic [12:0] da, input logic [7:0] dd);
        bit         ecg, edg, ew, crv, drv;
        logic [12:0] ea;
        logic [7:0]  ed;
        @(posedge clk);
        #1;
        rst = r;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        @(negedge clk);
        last_cpu_gnt    = cpu_gnt;
        last_cpu_rvalid = cpu_rvalid;
        last_dma_rvalid = dma_rvalid;
        last_cpu_rdata  = cpu_rdata;
        if (r) begin
            ecg = 1'b0; edg = 1'b0; ew = 1'b0; ea = '0; ed = '0; crv = 1'b0; drv = 1'b0;
        end else begin
            ecg = cr && (!dr || starve >= SMAX);
            edg = dr && !ecg;
            ew  = (ecg && cw) || (edg && dw);
            ea  = ecg ? ca : (edg ? da : 13'd0);
            ed  = ew ? (ecg ? cd : dd) : 8'd0;
            crv = pv && (po == OWN_CPU);
            drv = pv && (po == OWN_DMA);
        end
        chk("cpu_gnt",    cpu_gnt,    ecg);
        chk("dma_gnt",    dma_gnt,    edg);
        chk("sram_ce1",   sram_ce1,   ew);
        chk("sram_ce2",   sram_ce2,   ew);
        chk("sram_a",     sram_a,     ea);
        chk("sram_din",   sram_din,   ed);
        chk("sram_oe",    sram_oe,    crv || drv);
        chk("cpu_rvalid", cpu_rvalid, crv);
        chk("dma_rvalid", dma_rvalid, drv);
        chk("cpu_rdata",  cpu_rdata,  crv ? pd : 8'hFF);
        chk("dma_rdata",  dma_rdata,  drv ? pd : 8'hFF);
        if (r) begin
            starve = 0;
            pv = 1'b0;
        end else begin
            if (ecg || edg) begin
                if (ew) begin
                    sh[ea]  = ed;
                    shw[ea] = 1'b1;
                end
                pv = !ew;
                po = ecg ? OWN_CPU : OWN_DMA;
                pd = sh_read(ea);
            end else begin
                pv = 1'b0;
            end
            starve = (cr && !ecg) ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int nv;

        // Reset with requests active: everything must stay quiet.
        for (int i = 0; i < 3; i++)
            cycle(1, 1, 1'($urandom), 13'($urandom), 8'($urandom), 1, 1'($urandom), 13'($urandom), 8'($urandom));

        // Lone CPU read in the first cycle out of reset.
        cycle(0, 1, 0, 13'h0123, 0, 0, 0, 0, 0);
        chk("r026_gnt", last_cpu_gnt, 1'b1);
        idle(1);
        chk("r026_rvalid", last_cpu_rvalid, 1'b1);
        chk("r026_rdata", last_cpu_rdata, 8'h5A);
        chk("r026_dma_rvalid", last_dma_rvalid, 1'b0);

        // Continuous contention: CPU wins every fifth cycle.
        for (int i = 0; i < 15; i++) begin
            cycle(0, 1, 0, 13'($urandom), 0, 1, 0, 13'($urandom), 0);
            chk("r027_pattern", last_cpu_gnt, (i % 5) == 4);
        end
        idle(1);

        // DMA write then CPU read of the top address.
        cycle(0, 0, 0, 0, 0, 1, 1, 13'h1FFF, 8'hA5);
        cycle(0, 1, 0, 13'h1FFF, 0, 0, 0, 0, 0);
        idle(1);
        chk("r028_rdata", last_cpu_rdata, 8'hA5);

        // Alternating back-to-back reads.
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) cycle(0, 1, 0, 13'(i), 0, 0, 0, 0, 0);
            else            cycle(0, 0, 0, 0, 0, 1, 0, 13'(i), 0);
            if (i > 0) nv += int'(last_cpu_rvalid) + int'(last_dma_rvalid);
        end
        idle(1);
        nv += int'(last_cpu_rvalid) + int'(last_dma_rvalid);
        chk("r029_rvalid_count", nv, 8);

        // Build up starvation, read granted, then reset next cycle.
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 13'(i), 0, 1, 0, 13'(i + 8), 0);
        cycle(1, 1, 0, 0, 0, 1, 0, 0, 0);
        chk("r030_no_rvalid", last_dma_rvalid, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 0, 13'($urandom), 0, 1, 0, 13'($urandom), 0);
            chk("r030_starve_cleared", last_cpu_gnt, (i % 5) == 4);
        end
        idle(1);

        idle(10);

        // Randomized traffic with small address window and occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic [12:0] a1, a2;
            a1 = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 15)) : 13'($urandom);
            a2 = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 15)) : 13'($urandom);
            cycle(($urandom_range(0, 59) == 0),
                  1'($urandom), 1'($urandom), a1, 8'($urandom),
                  1'($urandom), 1'($urandom), a2, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wram_arbiter.md
WRAM_ARBITER -- requirements
Module: wram_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL set the maximum consecutive denied CPU request cycles before the CPU is forced a grant (range 1-15).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 cpu_req, cpu_we  input  1 each  CPU access request; 1 = write, 0 = read.
REQ-005 cpu_addr  input  13  CPU byte address; cpu_wdata  input  8  CPU write data.
REQ-006 cpu_gnt  output  1  CPU access accepted this cycle; cpu_rvalid  output  1  CPU read data valid; cpu_rdata  output  8.
REQ-007 dma_req, dma_we, dma_addr[13], dma_wdata[8], dma_gnt, dma_rvalid, dma_rdata[8] SHALL mirror the CPU ports for the OAM/HDMA engine.
REQ-008 sram_a  output  13; sram_din  output  8; sram_ce1, sram_ce2  output  1 each (write strobe, both high = write); sram_oe  output  1; sram_dout  input  8 (synchronous RAM, data one cycle after address).

Function
REQ-009 At most one requester SHALL be granted per cycle; a grant SHALL be combinational in the same cycle as its req.
REQ-010 Default priority: dma wins when both req high.
REQ-011 starve_cnt (4 bits) SHALL increment each cycle cpu_req=1 and cpu_gnt=0, saturating at STARVE_MAX, and clear on any cpu_gnt or cpu_req=0.
REQ-012 When starve_cnt==STARVE_MAX and cpu_req=1, cpu SHALL win over dma that cycle.
REQ-013 Granted write: sram_a=addr, sram_din=wdata, sram_ce1=sram_ce2=1 in the grant cycle; no rvalid generated.
REQ-014 Granted read: sram_a=addr, sram_ce1=sram_ce2=0 in the grant cycle; a registered tag (valid + owner) SHALL record the read.
REQ-015 Cycle after a read grant: sram_oe=1, owner's rvalid=1, owner's rdata=sram_dout; non-owner rvalid=0.
REQ-016 When no read tag is valid, sram_oe=0 and both rdata SHALL be 8'hFF.
REQ-017 Back-to-back reads (any owners) SHALL sustain one per cycle; tag update and rvalid of the previous read coincide without loss.
REQ-018 A write granted the cycle after a read SHALL not disturb that read's rvalid/rdata.
REQ-019 No grant: sram_ce1=sram_ce2=0, sram_a=0, sram_din=0.
REQ-020 gnt SHALL never assert without the matching req in the same cycle.

Reset
REQ-021 While rst=1: cpu_gnt=dma_gnt=0, both rvalid=0, sram_ce1=sram_ce2=0, sram_oe=0, sram_a=0, sram_din=0, both rdata=8'hFF.
REQ-022 rst SHALL clear starve_cnt and the read tag; a read granted the cycle before rst rises SHALL produce no rvalid.
REQ-023 First grant possible in the first cycle with rst=0.

Structure
REQ-024 Shared package wram_pkg SHALL hold owner enum (OWN_CPU, OWN_DMA), ADDR_W=13, DATA_W=8, and the 8'hFF idle-bus constant.
REQ-025 One sub-module natural: wram_prio_sel (combinational priority/starvation select); the SRAM itself SHALL be instantiated outside this block.

Verification
REQ-026 CPU read 0x0123 alone, RAM[0x0123]=0x5A -> cpu_gnt same cycle, cpu_rvalid=1 with cpu_rdata=0x5A next cycle, dma_rvalid=0.
REQ-027 CPU and DMA both req continuously, STARVE_MAX=4 -> dma granted 4 cycles, cpu granted 5th cycle, pattern repeats.
REQ-028 DMA write 0x1FFF=0xA5 then CPU read 0x1FFF next cycle -> cpu_rdata=0xA5, sram_ce1/ce2 high only in write cycle.
REQ-029 Alternating CPU/DMA reads 0x0000..0x0007 back-to-back -> 8 rvalids on consecutive cycles, each to correct owner with correct data.
REQ-030 Read granted, rst=1 next cycle -> no rvalid, all outputs at REQ-021 values, starve_cnt=0.
REQ-031 No requests for 10 cycles -> sram_ce1=ce2=oe=0, rdata=0xFF throughout.
